// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a request/ack instruction memory, tracks the fetch PC,
// and fills the IF/ID pipeline register while honouring stalls, flushes and branch redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_EN_IF,
    input  logic        reg_FD_EN,
    input  logic        reg_FD_stall,
    input  logic        reg_FD_flush,
    input  logic        Branch_ID,
    input  logic [31:0] PC_target_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] redirect_pc;
    logic [31:0] hold_buf;
    logic [31:0] target_aligned;
    logic [31:0] pc_next4;
    logic        stall;
    logic        redirect;
    logic        id_load;
    logic [31:0] id_load_inst;

    assign stall          = !PC_EN_IF | reg_FD_stall | !reg_FD_EN;
    assign redirect       = Branch_ID;
    assign target_aligned = PC_target_ID & ~32'd3;
    assign pc_next4       = PC_IF + 32'd4;

    // The address only changes when PC_IF changes, which happens only on an ack or from HOLD,
    // so it stays stable for the whole life of a request (including while discarding).
    assign imem_req   = (state != HOLD);
    assign imem_addr  = PC_IF & ~32'd3;
    assign fetch_busy = ((state == FETCH) && !imem_ack) || (state == DISCARD);

    always_comb begin
        id_load      = 1'b0;
        id_load_inst = hold_buf;
        case (state)
            FETCH: begin
                if (imem_ack && !redirect && !stall) begin
                    id_load      = 1'b1;
                    id_load_inst = imem_rdata;
                end
            end
            HOLD: begin
                if (!redirect && !stall) begin
                    id_load = 1'b1;
                end
            end
            default: begin
                id_load = 1'b0;
            end
        endcase
    end

    // Redirect beats stall: a stalled HOLD still drops its buffer when the branch resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            PC_IF       <= RESET_PC;
            redirect_pc <= 32'd0;
            hold_buf    <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            PC_IF <= target_aligned;
                        end else if (stall) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            PC_IF <= pc_next4;
                        end
                    end else if (redirect) begin
                        redirect_pc <= target_aligned;
                        state       <= DISCARD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        PC_IF    <= target_aligned;
                        hold_buf <= 32'd0;
                        state    <= FETCH;
                    end else if (!stall) begin
                        PC_IF <= pc_next4;
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        redirect_pc <= target_aligned;
                    end
                    if (imem_ack) begin
                        PC_IF <= redirect ? target_aligned : redirect_pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // IF/ID: flush wins, then stall holds, then a delivered instruction, otherwise a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_ID    <= 32'd0;
            inst_ID  <= NOP_INST;
            valid_ID <= 1'b0;
        end else if (reg_FD_flush) begin
            inst_ID  <= NOP_INST;
            valid_ID <= 1'b0;
        end else if (stall) begin
            PC_ID    <= PC_ID;
            inst_ID  <= inst_ID;
            valid_ID <= valid_ID;
        end else if (id_load) begin
            PC_ID    <= PC_IF;
            inst_ID  <= id_load_inst;
            valid_ID <= 1'b1;
        end else begin
            inst_ID  <= NOP_INST;
            valid_ID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stage and a variable-latency instruction memory.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en_if, fd_en, fd_stall, fd_flush, branch;
    logic [31:0] target;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr, pc_if, pc_id, inst_id;
    logic        valid_id, fetch_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .PC_EN_IF(pc_en_if), .reg_FD_EN(fd_en),
        .reg_FD_stall(fd_stall), .reg_FD_flush(fd_flush), .Branch_ID(branch),
        .PC_target_ID(target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC_IF(pc_if), .PC_ID(pc_id),
        .inst_ID(inst_id), .valid_ID(valid_id), .fetch_busy(fetch_busy)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc_en_if = 1'b1; fd_en = 1'b1; fd_stall = 1'b0; fd_flush = 1'b0;
        branch = 1'b0; target = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (pc_if !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_if got %h want %h", pc_if, 32'h0); end
        checks++; if (pc_id !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_id got %h want %h", pc_id, 32'h0); end
        checks++; if (inst_id !== NOP) begin errors++; $display("[TB] FAIL reset_inst got %h want %h", inst_id, NOP); end
        checks++; if (valid_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid_id); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h want %h", imem_addr, 32'h0); end
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got %b want 1", fetch_busy); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = word_at(imem_addr);
            #1;
            checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL seq_busy got %b want 0", fetch_busy); end
            tick();
            checks++; if (inst_id !== word_at(32'(4 * i))) begin errors++; $display("[TB] FAIL seq_inst got %h want %h", inst_id, word_at(32'(4 * i))); end
            checks++; if (pc_id !== 32'(4 * i) || valid_id !== 1'b1) begin errors++; $display("[TB] FAIL seq_pc_id got %h/%b want %h/1", pc_id, valid_id, 32'(4 * i)); end
        end
        checks++; if (pc_if !== 32'd12) begin errors++; $display("[TB] FAIL seq_pc_if got %h want %h", pc_if, 32'd12); end
    endtask

    task automatic test_stall_hold();
        imem_ack = 1'b1; imem_rdata = word_at(imem_addr);
        tick();
        fd_stall = 1'b1; imem_ack = 1'b1; imem_rdata = word_at(32'h10);
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req got %b want 0", imem_req); end
        checks++; if (pc_if !== 32'h10) begin errors++; $display("[TB] FAIL hold_pc_if got %h want %h", pc_if, 32'h10); end
        checks++; if (inst_id !== word_at(32'hC)) begin errors++; $display("[TB] FAIL hold_ifid got %h want %h", inst_id, word_at(32'hC)); end
        tick();
        checks++; if (imem_req !== 1'b0 || pc_if !== 32'h10) begin errors++; $display("[TB] FAIL hold2 got req %b pc %h want 0 %h", imem_req, pc_if, 32'h10); end
        fd_stall = 1'b0;
        tick();
        checks++; if (pc_id !== 32'h10 || valid_id !== 1'b1) begin errors++; $display("[TB] FAIL release_pc_id got %h/%b want %h/1", pc_id, valid_id, 32'h10); end
        checks++; if (inst_id !== word_at(32'h10)) begin errors++; $display("[TB] FAIL release_inst got %h want %h", inst_id, word_at(32'h10)); end
        checks++; if (pc_if !== 32'h14 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_pc_if got %h/%b want %h/1", pc_if, imem_req, 32'h14); end
    endtask

    task automatic test_discard();
        imem_ack = 1'b0; branch = 1'b1; target = 32'h103;
        tick();
        branch = 1'b0;
        #1;
        checks++; if (fetch_busy !== 1'b1 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL discard_busy got %b/%b want 1/1", fetch_busy, imem_req); end
        checks++; if (imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL discard_addr got %h want %h", imem_addr, 32'h14); end
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("[TB] FAIL discard_ack_busy got %b want 1", fetch_busy); end
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h100 || pc_if !== 32'h100) begin errors++; $display("[TB] FAIL discard_target got %h/%h want %h", imem_addr, pc_if, 32'h100); end
        checks++; if (valid_id !== 1'b0 || inst_id !== NOP) begin errors++; $display("[TB] FAIL discard_dropped got %b/%h want 0/%h", valid_id, inst_id, NOP); end
    endtask

    task automatic test_flush();
        imem_ack = 1'b1; imem_rdata = word_at(imem_addr);
        tick();
        checks++; if (valid_id !== 1'b1 || pc_id !== 32'h100) begin errors++; $display("[TB] FAIL preflush got %b/%h want 1/%h", valid_id, pc_id, 32'h100); end
        imem_ack = 1'b0; fd_flush = 1'b1; fd_stall = 1'b1;
        tick();
        fd_flush = 1'b0; fd_stall = 1'b0;
        checks++; if (valid_id !== 1'b0 || inst_id !== 32'h13) begin errors++; $display("[TB] FAIL flush_stall got %b/%h want 0/%h", valid_id, inst_id, 32'h13); end
    endtask

    task automatic test_wrap();
        branch = 1'b1; target = 32'hFFFF_FFFF; imem_ack = 1'b1; imem_rdata = $urandom;
        tick();
        branch = 1'b0;
        checks++; if (pc_if !== 32'hFFFF_FFFC || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_redirect got %h/%h want %h", pc_if, imem_addr, 32'hFFFF_FFFC); end
        imem_ack = 1'b1; imem_rdata = word_at(imem_addr);
        tick();
        checks++; if (pc_if !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc_if got %h want %h", pc_if, 32'h0); end
        checks++; if (pc_id !== 32'hFFFF_FFFC || inst_id !== word_at(32'hFFFF_FFFC)) begin errors++; $display("[TB] FAIL wrap_ifid got %h/%h want %h/%h", pc_id, inst_id, 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)); end
    endtask

    task automatic test_async_reset();
        imem_ack = 1'b1; imem_rdata = word_at(imem_addr);
        tick();
        imem_ack = 1'b0; fd_stall = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (pc_if !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL async_pc got %h/%h want %h", pc_if, imem_addr, 32'h0); end
        checks++; if (valid_id !== 1'b0 || inst_id !== NOP || pc_id !== 32'h0) begin errors++; $display("[TB] FAIL async_ifid got %b/%h/%h want 0/%h/0", valid_id, inst_id, pc_id, NOP); end
        @(negedge clk);
        rst = 1'b0; fd_stall = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL post_reset_req got %b/%h want 1/%h", imem_req, imem_addr, 32'h0); end
        imem_ack = 1'b1; imem_rdata = word_at(imem_addr);
        tick();
        imem_ack = 1'b0;
        checks++; if (pc_id !== 32'h0 || inst_id !== word_at(32'h0) || pc_if !== 32'h4) begin errors++; $display("[TB] FAIL post_reset_fetch got %h/%h/%h want 0/%h/4", pc_id, inst_id, pc_if, word_at(32'h0)); end
    endtask

    // Model keeps "have a buffered word" and "owe a redirect" flags rather than a state name.
    task automatic test_random();
        logic [31:0] m_pc, m_buf, m_rpc, m_inst, m_pcid, tgt, dinst, dpc;
        logic        m_held, m_pend, m_vld, a, s, r, deliver, req_before;
        int          cnt, lat;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_pc = 32'h0; m_buf = 32'h0; m_rpc = 32'h0; m_inst = NOP; m_pcid = 32'h0;
        m_held = 1'b0; m_pend = 1'b0; m_vld = 1'b0;
        cnt = 0; lat = $urandom_range(0, 3);
        for (int c = 0; c < 600; c++) begin
            checks++; if (pc_if !== m_pc) begin errors++; $display("[TB] FAIL rnd_pc_if cyc %0d got %h want %h", c, pc_if, m_pc); end
            checks++; if (imem_req !== !m_held) begin errors++; $display("[TB] FAIL rnd_req cyc %0d got %b want %b", c, imem_req, !m_held); end
            if (!m_held) begin
                checks++; if (imem_addr !== m_pc) begin errors++; $display("[TB] FAIL rnd_addr cyc %0d got %h want %h", c, imem_addr, m_pc); end
            end
            checks++; if (valid_id !== m_vld || inst_id !== m_inst) begin errors++; $display("[TB] FAIL rnd_ifid cyc %0d got %b/%h want %b/%h", c, valid_id, inst_id, m_vld, m_inst); end
            if (m_vld) begin
                checks++; if (pc_id !== m_pcid) begin errors++; $display("[TB] FAIL rnd_pc_id cyc %0d got %h want %h", c, pc_id, m_pcid); end
            end

            pc_en_if = ($urandom % 8) != 0;
            fd_en    = ($urandom % 10) != 0;
            fd_stall = ($urandom % 6) == 0;
            fd_flush = ($urandom % 12) == 0;
            branch   = ($urandom % 8) == 0;
            target   = $urandom;
            a = !m_held && (cnt >= lat);
            imem_ack = a;
            imem_rdata = a ? word_at(m_pc) : $urandom;
            #1;
            checks++; if (fetch_busy !== (m_pend || (!m_held && !a))) begin errors++; $display("[TB] FAIL rnd_busy cyc %0d got %b want %b", c, fetch_busy, m_pend || (!m_held && !a)); end

            s = !pc_en_if || fd_stall || !fd_en;
            r = branch;
            tgt = {target[31:2], 2'b00};
            deliver = 1'b0; dinst = 32'h0; dpc = m_pc;
            req_before = !m_held;
            if (m_held) begin
                if (r) begin m_held = 1'b0; m_pc = tgt; end
                else if (!s) begin deliver = 1'b1; dinst = m_buf; m_held = 1'b0; m_pc = m_pc + 32'd4; end
            end else if (m_pend) begin
                if (r) m_rpc = tgt;
                if (a) begin m_pc = m_rpc; m_pend = 1'b0; end
            end else if (a) begin
                if (r) m_pc = tgt;
                else if (s) begin m_held = 1'b1; m_buf = imem_rdata; end
                else begin deliver = 1'b1; dinst = imem_rdata; m_pc = m_pc + 32'd4; end
            end else if (r) begin
                m_pend = 1'b1; m_rpc = tgt;
            end
            if (fd_flush) begin m_vld = 1'b0; m_inst = NOP; end
            else if (s) begin end
            else if (deliver) begin m_vld = 1'b1; m_inst = dinst; m_pcid = dpc; end
            else begin m_vld = 1'b0; m_inst = NOP; end

            if (req_before && a) begin cnt = 0; lat = $urandom_range(0, 3); end
            else if (req_before) cnt++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_discard();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
